// File: rtl/hazard_scoreboard.sv
// Decode/execute hazard unit: operand forwarding, load-use and multi-cycle scoreboard stalls, branch flush.
// Define HAZARD_PERF_EN to add saturating stall-cycle and flush performance counters.
module hazard_scoreboard #(
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int XLEN   = 64,
   parameter int NFWD   = 3,
   parameter int MAXLAT = 8,
   parameter int CNTW   = $clog2(MAXLAT+1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 issue_valid,
   input  logic [AW-1:0]        issue_rs1,
   input  logic [AW-1:0]        issue_rs2,
   input  logic [AW-1:0]        issue_dst,
   input  logic                 issue_regwrite,
   input  logic                 issue_memread,
   input  logic [CNTW-1:0]      issue_lat,
   input  logic [XLEN-1:0]      rs1_rdata,
   input  logic [XLEN-1:0]      rs2_rdata,
   input  logic [NFWD-1:0]      fwd_valid,
   input  logic [NFWD*AW-1:0]   fwd_dst,
   input  logic [NFWD*XLEN-1:0] fwd_data,
   input  logic                 branch_taken,
   input  logic                 complete_valid,
   input  logic [AW-1:0]        complete_dst,
   output logic                 stall,
   output logic                 flush_if,
   output logic                 flush_id,
   output logic [XLEN-1:0]      srca,
   output logic [XLEN-1:0]      srcb,
   output logic                 srca_fwd,
   output logic                 srcb_fwd,
`ifdef HAZARD_PERF_EN
   output logic [31:0]          perf_stall_cycles,
   output logic [31:0]          perf_flushes,
`endif
   output logic [NREG-1:0]      busy
);

   localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(MAXLAT);
   localparam logic [AW-1:0]   REG_ZERO = AW'(0);
   localparam logic [NREG-1:0] BIT_ONE  = NREG'(1);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] pend;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] busy_nxt;
   logic [CNTW-1:0] lat_cnt;
   logic [CNTW-1:0] eff_lat;
   logic [AW-1:0]   ld_dst;
   logic            ld_v;
   logic            multi;
   logic            ld_hit;
   logic            sb_hit;
   logic            st_hit;
   logic            hazard;
   logic            accept;

   // Operand resolution: scan from oldest to youngest so the lowest matching source wins.
   always_comb begin
      srca     = rs1_rdata;
      srcb     = rs2_rdata;
      srca_fwd = 1'b0;
      srcb_fwd = 1'b0;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_dst[i*AW +: AW] == issue_rs1) && (issue_rs1 != REG_ZERO)) begin
            srca     = fwd_data[i*XLEN +: XLEN];
            srca_fwd = 1'b1;
         end else begin
            srca     = srca;
            srca_fwd = srca_fwd;
         end
         if (fwd_valid[i] && (fwd_dst[i*AW +: AW] == issue_rs2) && (issue_rs2 != REG_ZERO)) begin
            srcb     = fwd_data[i*XLEN +: XLEN];
            srcb_fwd = 1'b1;
         end else begin
            srcb     = srcb;
            srcb_fwd = srcb_fwd;
         end
      end
   end

   assign eff_lat = (issue_lat > CNT_MAX) ? CNT_MAX : issue_lat;
   assign multi   = (eff_lat > CNT_ONE);

   // A register completing this cycle no longer blocks its consumers.
   assign clr_mask = complete_valid ? (BIT_ONE << complete_dst) : NREG'(0);
   assign pend     = busy_q & ~clr_mask;

   assign ld_hit = ld_v && ((issue_rs1 == ld_dst) || (issue_rs2 == ld_dst));
   assign sb_hit = ((issue_rs1 != REG_ZERO) && pend[issue_rs1]) ||
                   ((issue_rs2 != REG_ZERO) && pend[issue_rs2]) ||
                   ((issue_dst != REG_ZERO) && pend[issue_dst]);
   assign st_hit = multi && (lat_cnt != CNT_ZERO);
   assign hazard = issue_valid && (ld_hit || sb_hit || st_hit);

   assign stall    = hazard && !branch_taken;
   assign flush_if = branch_taken;
   assign flush_id = branch_taken;
   assign accept   = issue_valid && !hazard && !branch_taken;

   assign set_mask = (accept && multi && issue_regwrite && (issue_dst != REG_ZERO)) ?
                     (BIT_ONE << issue_dst) : NREG'(0);
   assign busy_nxt = ((busy_q & ~clr_mask) | set_mask) & ~BIT_ONE;
   assign busy     = busy_q;

   // Scoreboard, structural latency counter and load-use tracker.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q  <= NREG'(0);
         lat_cnt <= CNT_ZERO;
         ld_v    <= 1'b0;
         ld_dst  <= REG_ZERO;
      end else begin
         busy_q <= busy_nxt;
         if (accept && multi) begin
            lat_cnt <= eff_lat - CNT_ONE;
         end else if (lat_cnt != CNT_ZERO) begin
            lat_cnt <= lat_cnt - CNT_ONE;
         end else begin
            lat_cnt <= lat_cnt;
         end
         if (branch_taken) begin
            ld_v <= 1'b0;
         end else if (accept) begin
            ld_v   <= issue_memread && issue_regwrite && (issue_dst != REG_ZERO);
            ld_dst <= issue_dst;
         end else if (issue_valid && ld_hit) begin
            ld_v <= 1'b0;
         end else begin
            ld_v <= ld_v;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   // Saturating performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cycles <= 32'd0;
         perf_flushes      <= 32'd0;
      end else begin
         if (stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end else begin
            perf_stall_cycles <= perf_stall_cycles;
         end
         if (branch_taken && (perf_flushes != 32'hFFFF_FFFF)) begin
            perf_flushes <= perf_flushes + 32'd1;
         end else begin
            perf_flushes <= perf_flushes;
         end
      end
   end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline's hazard/forwarding logic, sitting between decode and execute. Resolves RAW operands across NFWD forwarding sources and detects load-use hazards. Tracks in-flight multi-cycle writes in a per-register scoreboard, with a structural-busy counter for the multi-cycle unit. Generates stall and flush controls for the fetch/decode pipeline registers.

Parameters:
NREG, 32, architectural register count
AW, 5, register address width (matches creg_addr_t)
XLEN, 64, data width (matches word_t)
NFWD, 3, forwarding sources; index 0 youngest (execute), then memory, then writeback
MAXLAT, 8, maximum multi-cycle latency in cycles
CNTW, $clog2(MAXLAT+1), latency counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
issue_valid  in  1  decode holds a valid instruction
issue_rs1  in  AW  source register 1
issue_rs2  in  AW  source register 2
issue_dst  in  AW  destination register
issue_regwrite  in  1  instruction writes the regfile
issue_memread  in  1  instruction is a load
issue_lat  in  CNTW  execution latency; 0 or 1 means single-cycle
rs1_rdata  in  XLEN  regfile read, port 1
rs2_rdata  in  XLEN  regfile read, port 2
fwd_valid  in  NFWD  per-source regwrite valid
fwd_dst  in  NFWD*AW  per-source destination, packed with source 0 in the LSBs
fwd_data  in  NFWD*XLEN  per-source result, packed with source 0 in the LSBs
branch_taken  in  1  execute resolved a taken jump or branch
complete_valid  in  1  multi-cycle unit writes back this cycle
complete_dst  in  AW  multi-cycle writeback destination
stall  out  1  hold PC and the IF/ID register
flush_if  out  1  clear the IF/ID register
flush_id  out  1  clear the ID/EX register
srca  out  XLEN  resolved operand A
srcb  out  XLEN  resolved operand B
srca_fwd  out  1  operand A came from a forwarding source
srcb_fwd  out  1  operand B came from a forwarding source
busy  out  NREG  scoreboard pending bits; bit 0 is always 0

Behaviour:
- Reset (asynchronous): scoreboard, latency counter and load tracker clear. Consequently stall=0, flush_if=0, flush_id=0, srca_fwd=srcb_fwd=0, srca=rs1_rdata, srcb=rs2_rdata, busy=0.
- All outputs are combinational from inputs and state. There is no added latency.
- Forwarding:
  - A source i matches rsX when fwd_valid[i] is set, fwd_dst[i]==rsX and rsX!=0.
  - The lowest matching index wins and drives the operand; srcX_fwd=1.
  - If no source matches, the operand is the regfile value.
  - Register x0 always resolves to rsX_rdata and never forwards.
- Accepted issue: issue_valid && !stall && !branch_taken.
- Load-use:
  - On an accepted issue with issue_memread && issue_regwrite && issue_dst!=0, register ld_dst and set ld_v.
  - Any other accepted issue, or a flush, clears ld_v.
  - In the next cycle, if ld_v is set and issue_rs1 or issue_rs2 equals ld_dst, assert stall for exactly one cycle, then clear ld_v.
- Scoreboard:
  - An accepted issue with issue_lat>1, issue_regwrite and issue_dst!=0 sets busy[issue_dst].
  - complete_valid clears busy[complete_dst].
  - If set and clear target the same register in the same cycle, set wins.
  - stall asserts while busy[issue_rs1], busy[issue_rs2] or busy[issue_dst] is set (the last guards WAW), with the matching index nonzero.
- Latency counter:
  - An accepted issue with issue_lat>1 loads the counter with issue_lat-1.
  - Otherwise the counter decrements while nonzero, saturating at 0.
  - A new issue with issue_lat>1 while the counter is nonzero asserts stall (structural hazard).
  - issue_lat>MAXLAT is clamped to MAXLAT.
- Branch:
  - branch_taken asserts flush_if=flush_id=1 in the same cycle.
  - Flush overrides stall: stall is forced to 0 and the issue is not accepted.
  - Already-issued multi-cycle ops are not cancelled; their busy bits clear on completion.
- With issue_valid=0: stall=0, and no state changes except counter decrement and completion clears.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs perf_stall_cycles (32) and perf_flushes (32).
  - perf_stall_cycles increments on each cycle with stall=1.
  - perf_flushes increments on each cycle with branch_taken=1.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forward priority: fwd_valid=3'b111, all fwd_dst=5, fwd_data={30,20,10} (source 0 LSBs), issue_rs1=5 -> srca=10, srca_fwd=1. Same stimulus with rs1=0 -> srca=rs1_rdata, srca_fwd=0.
- Load-use: accept a load with dst=7, then issue rs2=7 -> stall=1 for exactly one cycle, then stall=0 and the issue is accepted. Same case with dst=0 -> never stalls.
- Multi-cycle: issue dst=9, lat=4 -> busy[9]=1; a dependent rs1=9 stalls until complete_valid with complete_dst=9, then stall=0 the same cycle. A second lat=3 issue during the counter window stalls 3 cycles.
- Simultaneous set/clear: complete_dst=9 while a new lat=4 issue targets dst=9 -> busy[9] stays 1.
- Branch override: busy[4]=1, issue rs1=4, branch_taken=1 -> stall=0, flush_if=flush_id=1, no scoreboard change. With HAZARD_PERF_EN, perf_flushes increments by 1.
- Reset mid-operation: assert reset with busy[9]=1, counter=2, ld_v=1 -> all outputs immediately at their reset values, busy=0, and the next issue is accepted without stall.
